seg_capture_decoder: RTL and testbench
======================================

SEG_CAPTURE_DECODER -- requirements
Module: seg_capture_decoder

Interface
REQ-001 The block SHALL have one parameter, STABLE_TICKS, default 3, giving the number of consecutive identical samples needed to accept a reading; legal range is 1..15.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high; it SHALL force all state to reset values immediately, independent of clock.
REQ-004 tick  input  1  sample strobe from the frame-rate tick generator; each clock cycle with tick=1 SHALL count as one sample.
REQ-005 seg0  input  7  active-low segment pattern of the low digit; bit0=a through bit6=g.
REQ-006 seg1  input  7  active-low segment pattern of the high digit, with the same bit mapping.
REQ-007 value  output  8  last accepted reading as {digit1[3:0], digit0[3:0]}.
REQ-008 valid  output  1  one-cycle pulse when value is updated.
REQ-009 error  output  1  one-cycle pulse when a sample contains an undecodable pattern.
REQ-010 locked  output  1  level output; high while the state is LOCKED.

Function
REQ-011 Each digit SHALL be decoded with this table (hex code -> digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-012 Any other 7-bit pattern on either digit SHALL make the sample invalid.
REQ-013 Decoding SHALL be combinational and SHALL be used only on cycles where tick=1; when tick=0, no state SHALL change and valid and error SHALL be 0.
REQ-014 The FSM SHALL have three states: IDLE, TRACK and LOCKED; internal registers are cand[7:0] and cnt[3:0].
REQ-015 An invalid sample in any state SHALL:
  - drive error=1 on the next cycle;
  - set cnt=0 and move to IDLE;
  - leave value unchanged.
REQ-016 In IDLE, a valid sample with decoded pair P SHALL:
  - set cand=P and cnt=1;
  - move to TRACK, or go directly to the accept action of REQ-018 when STABLE_TICKS=1.
REQ-017 In TRACK, a valid sample with P!=cand SHALL set cand=P and cnt=1 and stay in TRACK.
REQ-018 In TRACK, a valid sample with P==cand SHALL set cnt=cnt+1; when cnt+1==STABLE_TICKS it SHALL:
  - set value=P;
  - pulse valid;
  - move to LOCKED.
REQ-019 In LOCKED, a valid sample with P==value SHALL change nothing, with no valid pulse.
REQ-020 In LOCKED, a valid sample with P!=value SHALL:
  - set cand=P and cnt=1;
  - move to TRACK;
  - hold value unchanged until the new reading is accepted.
REQ-021 valid and error SHALL be registered: asserted for exactly one cycle, in the cycle after the clock edge that sampled the qualifying tick, so latency is 1 cycle from the tick edge.
REQ-022 valid and error SHALL never be 1 in the same cycle.
REQ-023 cnt SHALL never exceed STABLE_TICKS, and no wrap-around SHALL occur.
REQ-024 locked SHALL equal (state==LOCKED) and be driven from a register.
REQ-025 If tick stays high for several cycles, each such cycle SHALL be processed as a separate sample.

Reset
REQ-026 While reset=1, the block SHALL hold these values:
  - state=IDLE, cnt=0, cand=8'h00, value=8'h00;
  - valid=0, error=0, locked=0.
REQ-027 Reset SHALL take priority over tick in the same cycle.
REQ-028 Reset asserted mid-TRACK or mid-LOCKED SHALL discard any partial count.
REQ-029 After reset release, the first sample SHALL be handled as from IDLE.

Verification
REQ-030 With STABLE_TICKS=3, seg1=79 and seg0=06 for 3 ticks, the bench SHALL see valid=1 one cycle after the third tick, value=8'h1E and locked=1; the first two ticks SHALL give no pulse.
REQ-031 From the locked 8'h1E state, setting seg0=40 then seg0=79 on alternating ticks for 6 ticks SHALL produce no valid pulse, locked=0 after the first tick, and value held at 8'h1E.
REQ-032 Setting seg0=7F (blank) on one tick in TRACK with cnt=2 SHALL give error=1 for one cycle, state IDLE, and no valid pulse; three further good ticks SHALL be needed to lock.
REQ-033 Asserting reset asynchronously between clock edges in LOCKED SHALL immediately set value=8'h00 and locked=0, and a tick in the same cycle SHALL be ignored.
REQ-034 With tick held high for 3 consecutive cycles on a stable pattern 40/40, the bench SHALL see lock after the 3rd cycle with value=8'h00 and a single valid pulse.
REQ-035 With STABLE_TICKS=1, a single valid tick SHALL give a valid pulse on the next cycle, and repeating the same pattern SHALL give no further pulses.

Source files
------------

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder
//   Decodes a two-digit active-low 7-segment display into a hex byte and
//   accepts a reading only after it has been seen on STABLE_TICKS
//   consecutive sample ticks.
//
// Parameters
//   STABLE_TICKS  consecutive identical samples required to accept (1..15)
//
// Ports
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   tick    sample strobe; each high cycle is one sample
//   seg0    low digit, active-low segments, bit0=a .. bit6=g
//   seg1    high digit, same mapping
//   value   last accepted reading {digit1, digit0}
//   valid   one-cycle pulse when value updates
//   error   one-cycle pulse when a sample holds an undecodable pattern
//   locked  high while in LOCKED
module seg_capture_decoder #(
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  output logic [7:0] value,
  output logic       valid,
  output logic       error,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] STABLE_W = 5'(STABLE_TICKS);

  state_t     state, state_n;
  logic [7:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] value_n;
  logic       valid_n, error_n;

  logic [4:0] dec0, dec1;
  logic       pair_ok;
  logic [7:0] pair;
  logic [4:0] cnt_inc;
  logic       start_new, accept;

  // Returns {ok, digit}; ok=0 for any pattern outside the table.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h18:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    dec0    = decode(seg0);
    dec1    = decode(seg1);
    pair_ok = dec0[4] & dec1[4];
    pair    = {dec1[3:0], dec0[3:0]};
    cnt_inc = {1'b0, cnt} + 5'd1;
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    value_n   = value;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    start_new = 1'b0;
    accept    = 1'b0;

    if (tick) begin
      if (!pair_ok) begin
        error_n = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end else begin
        unique case (state)
          IDLE:   start_new = 1'b1;
          TRACK: begin
            if (pair == cand) begin
              cnt_n = cnt_inc[3:0];
              if (cnt_inc == STABLE_W) accept = 1'b1;
            end else begin
              start_new = 1'b1;
            end
          end
          LOCKED: if (pair != value) start_new = 1'b1;
          default: state_n = IDLE;
        endcase

        // A fresh candidate already satisfies a one-sample requirement, so
        // with STABLE_TICKS=1 it is accepted on the spot from any state.
        if (start_new) begin
          cand_n = pair;
          cnt_n  = 4'd1;
          if (STABLE_W == 5'd1) accept = 1'b1;
          else                  state_n = TRACK;
        end

        if (accept) begin
          value_n = pair;
          valid_n = 1'b1;
          state_n = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cand   <= '0;
      cnt    <= '0;
      value  <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      cnt    <= cnt_n;
      value  <= value_n;
      valid  <= valid_n;
      error  <= error_n;
      locked <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Testbench for seg_capture_decoder: two instances (STABLE_TICKS=3 and 1)
// share the same stimulus; a run-length reference model predicts every
// output and is compared on each falling edge, plus directed scenarios
// with hand-computed expectations.
module tb_seg_capture_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic [6:0] seg0  = 7'h7F;
  logic [6:0] seg1  = 7'h7F;

  logic [7:0] u3_value, u1_value;
  logic       u3_valid, u3_error, u3_locked;
  logic       u1_valid, u1_error, u1_locked;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seg_capture_decoder #(.STABLE_TICKS(3)) u3 (
    .clock(clock), .reset(reset), .tick(tick), .seg0(seg0), .seg1(seg1),
    .value(u3_value), .valid(u3_valid), .error(u3_error), .locked(u3_locked)
  );

  seg_capture_decoder #(.STABLE_TICKS(1)) u1 (
    .clock(clock), .reset(reset), .tick(tick), .seg0(seg0), .seg1(seg1),
    .value(u1_value), .valid(u1_valid), .error(u1_error), .locked(u1_locked)
  );

  // Segment code for each hex digit, index = digit value.
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int lookup(input logic [6:0] s);
    lookup = -1;
    for (int d = 0; d < 16; d++) if (codes[d] == s) lookup = d;
  endfunction

  // Model: run length of identical valid samples since the last break.
  int         st     [2] = '{3, 1};
  logic [7:0] m_val  [2];
  logic [7:0] m_last [2];
  int         m_run  [2];
  logic       m_lock [2];
  logic       m_vld  [2];
  logic       m_err  [2];

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_val[i] <= '0; m_last[i] <= '0; m_run[i] <= 0;
        m_lock[i] <= 1'b0; m_vld[i] <= 1'b0; m_err[i] <= 1'b0;
      end else begin
        automatic int         d0 = lookup(seg0);
        automatic int         d1 = lookup(seg1);
        automatic logic [7:0] p = 8'(d1 * 16 + d0);
        automatic int         run = m_run[i];
        automatic logic [7:0] last = m_last[i];
        automatic logic [7:0] val = m_val[i];
        automatic logic       lk = m_lock[i];
        automatic logic       vd = 1'b0;
        automatic logic       er = 1'b0;
        if (tick) begin
          if (d0 < 0 || d1 < 0) begin
            er = 1'b1; run = 0; lk = 1'b0;
          end else if (!(lk && p == val)) begin
            if (!lk && run > 0 && p == last) run = run + 1;
            else begin run = 1; last = p; end
            lk = 1'b0;
            if (run == st[i]) begin val = p; vd = 1'b1; lk = 1'b1; end
          end
        end
        m_val[i] <= val; m_last[i] <= last; m_run[i] <= run;
        m_lock[i] <= lk; m_vld[i] <= vd; m_err[i] <= er;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("u3_value",  u3_value,  m_val[0]);
    chk("u3_valid",  {7'd0, u3_valid},  {7'd0, m_vld[0]});
    chk("u3_error",  {7'd0, u3_error},  {7'd0, m_err[0]});
    chk("u3_locked", {7'd0, u3_locked}, {7'd0, m_lock[0]});
    chk("u3_excl",   {7'd0, u3_valid & u3_error}, 8'd0);
    chk("u1_value",  u1_value,  m_val[1]);
    chk("u1_valid",  {7'd0, u1_valid},  {7'd0, m_vld[1]});
    chk("u1_error",  {7'd0, u1_error},  {7'd0, m_err[1]});
    chk("u1_locked", {7'd0, u1_locked}, {7'd0, m_lock[1]});
  end

  // Drive one cycle at a falling edge, return at the next falling edge.
  task automatic step(input logic t, input logic [6:0] s1, input logic [6:0] s0);
    tick = t; seg1 = s1; seg0 = s0;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [6:0] pick();
    int r = $urandom_range(0, 19);
    if (r < 6)  return 7'h40;
    if (r < 12) return 7'h79;
    if (r < 17) return 7'h24;
    return 7'($urandom);
  endfunction

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_value",  u3_value, 8'h00);
    chk("rst_locked", {7'd0, u3_locked}, 8'd0);
    chk("rst_valid",  {7'd0, u3_valid}, 8'd0);
    reset = 1'b0;
    step(1'b0, 7'h7F, 7'h7F);

    // Three ticks of "1E" lock the 3-tick instance on the third.
    step(1'b1, 7'h79, 7'h06); chk("d30_t1_valid", {7'd0, u3_valid}, 8'd0);
    step(1'b1, 7'h79, 7'h06); chk("d30_t2_valid", {7'd0, u3_valid}, 8'd0);
    step(1'b1, 7'h79, 7'h06);
    chk("d30_valid",  {7'd0, u3_valid}, 8'd1);
    chk("d30_value",  u3_value, 8'h1E);
    chk("d30_locked", {7'd0, u3_locked}, 8'd1);
    step(1'b0, 7'h79, 7'h06); chk("d30_pulse_end", {7'd0, u3_valid}, 8'd0);

    // Alternating low digit never stabilises.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 7'h79, (i % 2 == 0) ? 7'h40 : 7'h79);
      if (i == 0) chk("d31_unlock", {7'd0, u3_locked}, 8'd0);
      chk("d31_valid", {7'd0, u3_valid}, 8'd0);
      chk("d31_value", u3_value, 8'h1E);
    end

    // Blank digit at cnt=2 restarts the count.
    step(1'b1, 7'h79, 7'h06);
    step(1'b1, 7'h79, 7'h06);
    step(1'b1, 7'h79, 7'h7F);
    chk("d32_error", {7'd0, u3_error}, 8'd1);
    chk("d32_valid", {7'd0, u3_valid}, 8'd0);
    chk("d32_value", u3_value, 8'h1E);
    step(1'b0, 7'h79, 7'h06); chk("d32_err_end", {7'd0, u3_error}, 8'd0);
    step(1'b1, 7'h79, 7'h06);
    step(1'b1, 7'h79, 7'h06); chk("d32_no_early", {7'd0, u3_valid}, 8'd0);
    step(1'b1, 7'h79, 7'h06); chk("d32_relock", {7'd0, u3_valid}, 8'd1);
    step(1'b0, 7'h79, 7'h06);

    // Asynchronous reset between edges while locked.
    #2 reset = 1'b1;
    #1;
    chk("d33_value",  u3_value, 8'h00);
    chk("d33_locked", {7'd0, u3_locked}, 8'd0);
    tick = 1'b1; seg1 = 7'h40; seg0 = 7'h40;
    @(posedge clock); @(negedge clock);
    chk("d33_tick_ignored", {7'd0, u3_valid}, 8'd0);
    reset = 1'b0;

    // tick held high three cycles on 40/40.
    step(1'b1, 7'h40, 7'h40); chk("d34_t1", {7'd0, u3_valid}, 8'd0);
    step(1'b1, 7'h40, 7'h40); chk("d34_t2", {7'd0, u3_valid}, 8'd0);
    step(1'b1, 7'h40, 7'h40);
    chk("d34_valid",  {7'd0, u3_valid}, 8'd1);
    chk("d34_value",  u3_value, 8'h00);
    chk("d34_locked", {7'd0, u3_locked}, 8'd1);
    step(1'b1, 7'h40, 7'h40); chk("d34_single", {7'd0, u3_valid}, 8'd0);

    // One-tick instance accepts immediately and only once.
    step(1'b1, 7'h24, 7'h30);
    chk("d35_valid", {7'd0, u1_valid}, 8'd1);
    chk("d35_value", u1_value, 8'h23);
    step(1'b1, 7'h24, 7'h30); chk("d35_rep1", {7'd0, u1_valid}, 8'd0);
    step(1'b1, 7'h24, 7'h30); chk("d35_rep2", {7'd0, u1_valid}, 8'd0);

    // Random phase; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 3) != 0), pick(), pick());
    end
    reset = 1'b0;
    step(1'b0, 7'h7F, 7'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
